// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter: mono sample serialized onto both channels
module i2s_tx #(
  parameter int DATA_BITS = 16,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [DATA_BITS-1:0] din,
  output logic                 sample_req,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata
);

  localparam int SLOTS = 2 * DATA_BITS;
  localparam int CW    = $clog2(SLOTS);
  localparam int IW    = $clog2(DATA_BITS);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);
  localparam logic [CW-1:0] HALF      = CW'(DATA_BITS);
  localparam logic [CW-1:0] SLOT_ONE  = CW'(1);
  localparam logic [IW-1:0] TOP_IDX   = IW'(DATA_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

  logic [DW-1:0]        div_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [CW-1:0]        bit_nxt;
  logic [CW-1:0]        pos;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] hold_reg;
  logic [DATA_BITS-1:0] frame_word;
  logic [DATA_BITS-1:0] word_sel;
  logic                 req_d1;
  logic                 req_d2;
  logic                 sdata_nxt;

  // Next slot's bit; slot 1 already uses the word being loaded this clk.
  always_comb begin
    bit_nxt   = (bit_cnt == LAST_SLOT) ? '0 : bit_cnt + SLOT_ONE;
    word_sel  = (bit_nxt == SLOT_ONE) ? hold_reg : frame_word;
    pos       = (bit_cnt >= HALF) ? bit_cnt - HALF : bit_cnt;
    idx       = TOP_IDX - pos[IW-1:0];
    sdata_nxt = (bit_nxt == '0) ? frame_word[0] : word_sel[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bclk       <= 1'b0;
      bit_cnt    <= LAST_SLOT;
      lrclk      <= 1'b1;
      sdata      <= 1'b0;
      sample_req <= 1'b0;
      req_d1     <= 1'b0;
      req_d2     <= 1'b0;
      hold_reg   <= '0;
      frame_word <= '0;
    end else if (!run) begin
      // Idle drops any capture still in flight; sample registers are kept.
      div_cnt    <= '0;
      bclk       <= 1'b0;
      bit_cnt    <= LAST_SLOT;
      lrclk      <= 1'b1;
      sdata      <= 1'b0;
      sample_req <= 1'b0;
      req_d1     <= 1'b0;
      req_d2     <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      req_d1     <= sample_req;
      req_d2     <= req_d1;
      if (req_d2) begin
        hold_reg <= din;
      end
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
        if (bclk) begin
          bit_cnt    <= bit_nxt;
          lrclk      <= (bit_nxt >= HALF);
          sdata      <= sdata_nxt;
          sample_req <= (bit_nxt == '0);
          if (bit_nxt == SLOT_ONE) begin
            frame_word <= hold_reg;
          end
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed self-checking bench for i2s_tx
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        sample_req;
  logic        bclk;
  logic        lrclk;
  logic        sdata;

  int checks = 0;
  int errors = 0;
  int n;

  i2s_tx #(.DATA_BITS(16), .CLK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .din        (din),
    .sample_req (sample_req),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Negedges until sample_req is seen; -1 if it never comes.
  task automatic wait_req(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!sample_req && cnt < 300);
    if (!sample_req) cnt = -1;
  endtask

  // Starts on the negedge where sample_req is high (slot 0); ends on the next slot 0.
  task automatic run_frame(input logic [15:0] word, input bit junk, input string tag);
    logic [15:0] left;
    logic [15:0] right;
    logic        prev;
    int          slot;
    int          lr_err;
    int          req_cnt;
    left = '0; right = '0; slot = 0; lr_err = 0; req_cnt = 0;
    prev = bclk;
    for (int cyc = 1; cyc <= 256; cyc++) begin
      @(negedge clk);
      if (cyc == 2) din = word;
      else if (junk) din = 16'($urandom);
      if (sample_req) req_cnt++;
      if (prev && !bclk) begin
        slot++;
        if (slot <= 16) left[16 - slot] = sdata;
        else if (slot <= 32) right[32 - slot] = sdata;
        if (lrclk !== ((slot >= 16 && slot <= 31) ? 1'b1 : 1'b0)) lr_err++;
      end
      prev = bclk;
    end
    check({tag, " left"}, 32'(left), 32'(word));
    check({tag, " right"}, 32'(right), 32'(word));
    check({tag, " lrclk"}, lr_err, 0);
    check({tag, " slots"}, slot, 32);
    check({tag, " req_count"}, req_cnt, 1);
    check({tag, " req_end"}, 32'(sample_req), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("rst bclk", 32'(bclk), 0);
    check("rst lrclk", 32'(lrclk), 1);
    check("rst sdata", 32'(sdata), 0);
    check("rst sample_req", 32'(sample_req), 0);

    rst_n = 1'b1;
    wait_req(n);
    check("start latency", n, 8);
    check("start lrclk", 32'(lrclk), 0);
    check("start bclk", 32'(bclk), 0);
    check("start sdata", 32'(sdata), 0);

    run_frame(16'hA5C3, 1'b0, "a5c3");
    run_frame(16'h3C96, 1'b1, "junk_din");
    run_frame(16'h8000, 1'b0, "8000");
    run_frame(16'h7FFF, 1'b0, "7fff");

    for (int cyc = 1; cyc <= 72; cyc++) begin
      @(negedge clk);
      if (cyc == 2) din = 16'hFFFF;
    end
    check("slot9 sdata", 32'(sdata), 1);
    run = 1'b0;
    @(negedge clk);
    check("drop bclk", 32'(bclk), 0);
    check("drop lrclk", 32'(lrclk), 1);
    check("drop sdata", 32'(sdata), 0);
    check("drop sample_req", 32'(sample_req), 0);
    repeat (20) @(negedge clk);
    check("idle sample_req", 32'(sample_req), 0);
    check("idle lrclk", 32'(lrclk), 1);
    run = 1'b1;
    wait_req(n);
    check("resume latency", n, 8);
    run_frame(16'h1357, 1'b0, "resume");

    for (int cyc = 1; cyc <= 54; cyc++) begin
      @(negedge clk);
      if (cyc == 2) din = 16'hBEEF;
    end
    check("pre_rst bclk", 32'(bclk), 1);
    check("pre_rst sdata", 32'(sdata), 1);
    rst_n = 1'b0;
    din = 16'h0000;
    #1;
    check("async bclk", 32'(bclk), 0);
    check("async lrclk", 32'(lrclk), 1);
    check("async sdata", 32'(sdata), 0);
    check("async sample_req", 32'(sample_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_req(n);
    check("post_rst latency", n, 8);
    check("post_rst slot0", 32'(sdata), 0);
    run_frame(16'h0000, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
